// File: rtl/matrix_c_collector_pkg.sv
// Shared types and constants for the result collector (package matrix_pkg).
package matrix_pkg;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;
endpackage

// File: rtl/matrix_c_collector_if.sv
// Collector bus: start/lane inputs, status outputs and the random-read port.
// The clr input exists only when COLLECTOR_ACCUM_EN is defined.
interface matrix_c_collector_if #(
  parameter int unsigned WIDTH = 32
);
  logic                        start;
  logic [3:0]                  vld;
  logic [WIDTH-1:0]            q0;
  logic [WIDTH-1:0]            q1;
  logic [WIDTH-1:0]            q2;
  logic [WIDTH-1:0]            q3;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic                        rd_en;
  logic [matrix_pkg::ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]            rd_data;
  logic                        rd_vld;
`ifdef COLLECTOR_ACCUM_EN
  logic                        clr;
`endif

  modport master (
`ifdef COLLECTOR_ACCUM_EN
    output clr,
`endif
    output start, vld, q0, q1, q2, q3, rd_en, rd_addr,
    input  busy, done, err, rd_data, rd_vld
  );

  modport slave (
`ifdef COLLECTOR_ACCUM_EN
    input  clr,
`endif
    input  start, vld, q0, q1, q2, q3, rd_en, rd_addr,
    output busy, done, err, rd_data, rd_vld
  );
endinterface

// File: rtl/matrix_c_collector_lane_counter.sv
// Per-lane row counter: counts accepted rows, saturates with a full flag
// and strobes ovf for any increment request once full.
module lane_counter
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o,
  output logic       full_o,
  output logic       ovf_o
);
  logic [1:0] cnt_q, cnt_d;
  logic       full_q, full_d;

  always_comb begin
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clr_i) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (inc_i && !full_q) begin
      // the count stays on the last row; full marks the fourth accepted row
      if (cnt_q == 2'(ROWS - 1)) full_d = 1'b1;
      else                       cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = full_q;
  assign ovf_o  = inc_i & full_q;
endmodule

// File: rtl/matrix_c_collector.sv
// De-skews four result lanes into a row-major stride x 4 matrix with a
// registered read port. COLLECTOR_ACCUM_EN selects accumulate-on-write plus clr.
module matrix_c_collector
  import matrix_pkg::*;
#(
  parameter int unsigned STRIDE = 4,
  parameter int unsigned WIDTH  = 32
) (
  input logic                 clk,
  input logic                 reset,
  matrix_c_collector_if.slave bus
);
  localparam int unsigned DEPTH  = ROWS * STRIDE;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [4:0]        wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_vld_q;

  logic [WIDTH-1:0]  lane_data [LANES];
  logic [1:0]        cnt [LANES];
  logic [MEM_AW-1:0] waddr [LANES];
  logic [LANES-1:0]  inc, full, ovf, we;
  logic [2:0]        n_wr;
  logic              collect, final_wr;

  assign lane_data[0] = bus.q0;
  assign lane_data[1] = bus.q1;
  assign lane_data[2] = bus.q2;
  assign lane_data[3] = bus.q3;

  // start takes priority: a same-cycle vld is neither written nor flagged
  assign collect = (state_q == COLLECT);
  assign inc     = bus.vld & {LANES{collect & ~bus.start}};
  assign we      = inc & ~full;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_counter u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (bus.start),
      .inc_i  (inc[k]),
      .cnt_o  (cnt[k]),
      .full_o (full[k]),
      .ovf_o  (ovf[k])
    );
    assign waddr[k] = MEM_AW'(32'(cnt[k]) * STRIDE + 32'(k));
  end

  assign n_wr     = 3'($countones(we));
  assign final_wr = collect && ((wcnt_q + 5'(n_wr)) == 5'(LANES * ROWS));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    if (bus.start) begin
      state_d = COLLECT;
      wcnt_d  = '0;
      err_d   = 1'b0;
    end else begin
      wcnt_d = wcnt_q + 5'(n_wr);
      if (((|bus.vld) && !collect) || (|ovf)) err_d = 1'b1;
      unique case (state_q)
        IDLE:    state_d = IDLE;
        COLLECT: if (final_wr) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      rd_vld_q <= bus.rd_en;
      if (bus.rd_en) begin
        if (32'(bus.rd_addr) < DEPTH) rd_data_q <= mem_q[MEM_AW'(bus.rd_addr)];
        else                          rd_data_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
`ifdef COLLECTOR_ACCUM_EN
    end else if (bus.clr) begin
      mem_q <= '{default: '0};
    end else begin
      for (int unsigned k = 0; k < LANES; k++)
        if (we[k]) mem_q[waddr[k]] <= mem_q[waddr[k]] + lane_data[k];
    end
`else
    end else if (bus.start) begin
      mem_q <= '{default: '0};
    end else begin
      for (int unsigned k = 0; k < LANES; k++)
        if (we[k]) mem_q[waddr[k]] <= lane_data[k];
    end
`endif
  end

  assign bus.busy    = collect;
  assign bus.done    = (state_q == DONE);
  assign bus.err     = err_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld  = rd_vld_q;
endmodule

// File: tb/tb_matrix_c_collector.sv
// Directed + randomized bench for matrix_c_collector against a matrix-level
// reference model; honours COLLECTOR_ACCUM_EN when defined.
module tb_matrix_c_collector;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matrix_c_collector_if #(.WIDTH(W)) bus ();
  matrix_c_collector #(.STRIDE(4), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: result matrix, rows accepted per lane, collection status
  logic [W-1:0] m [16];
  int           mc [4];
  int           mwr;
  bit           mcol, merr, mdone;
  logic [W-1:0] exp_rd;
  bit           exp_rv;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_q(input int k, input logic [W-1:0] v);
    case (k)
      0: bus.q0 = v;
      1: bus.q1 = v;
      2: bus.q2 = v;
      default: bus.q3 = v;
    endcase
  endtask

  function automatic logic [W-1:0] get_q(input int k);
    case (k)
      0: return bus.q0;
      1: return bus.q1;
      2: return bus.q2;
      default: return bus.q3;
    endcase
  endfunction

  // Apply the currently driven inputs for one clock, update the model, check outputs.
  task automatic cycle();
    logic [W-1:0] old [16];
    int a;
    old   = m;
    mdone = 0;
    if (reset) begin
      m      = '{default: '0};
      mc     = '{default: 0};
      mwr    = 0;
      mcol   = 0;
      merr   = 0;
      exp_rd = '0;
      exp_rv = 0;
    end else begin
      exp_rv = bus.rd_en;
      if (bus.rd_en) exp_rd = old[bus.rd_addr];
      if (bus.start) begin
        mc   = '{default: 0};
        mwr  = 0;
        merr = 0;
        mcol = 1;
`ifndef COLLECTOR_ACCUM_EN
        m = '{default: '0};
`endif
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (bus.vld[k]) begin
            if (!mcol || mc[k] == 4) merr = 1;
            else begin
              a = mc[k] * 4 + k;
`ifdef COLLECTOR_ACCUM_EN
              m[a] = m[a] + get_q(k);
`else
              m[a] = get_q(k);
`endif
              mc[k]++;
              mwr++;
            end
          end
        end
        if (mcol && mwr == 16) begin
          mcol  = 0;
          mdone = 1;
        end
      end
`ifdef COLLECTOR_ACCUM_EN
      if (bus.clr) m = '{default: '0};
`endif
    end
    @(posedge clk);
    #1;
    check("busy", bus.busy, mcol);
    check("done", bus.done, mdone);
    check("err", bus.err, merr);
    check("rd_vld", bus.rd_vld, exp_rv);
    check("rd_data", bus.rd_data, exp_rd);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic clr_mem();
`ifdef COLLECTOR_ACCUM_EN
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
`endif
  endtask

  task automatic rd_check(input int a, input logic [W-1:0] exp, input string tag);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'(a);
    cycle();
    bus.rd_en = 1'b0;
    check(tag, bus.rd_data, exp);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 4'(a);
      cycle();
    end
    bus.rd_en = 1'b0;
  endtask

  // Natural skew: lane k carries row c-k in cycle c; optional fifth beat on lane 2.
  task automatic feed_skew(input bit ones, input bit extra2);
    int r;
    for (int c = 0; c < 7; c++) begin
      bus.vld = '0;
      for (int k = 0; k < 4; k++) begin
        r = c - k;
        if (r >= 0 && r < 4) begin
          bus.vld[k] = 1'b1;
          set_q(k, ones ? '1 : W'(256 * r + k));
        end
      end
      if (extra2 && c == 6) begin
        bus.vld[2] = 1'b1;
        set_q(2, 32'hDEADBEEF);
      end
      bus.rd_en   = (c == 1 || c == 2);
      bus.rd_addr = 4'd1;
      cycle();
      if (c == 5) check("busy_t6", bus.busy, 1'b1);
      if (c == 6) begin
        check("done_t7", bus.done, 1'b1);
        check("busy_t7", bus.busy, 1'b0);
      end
    end
    bus.vld   = '0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    int c;
    bus.start   = 1'b0;
    bus.vld     = '0;
    bus.q0      = '0;
    bus.q1      = '0;
    bus.q2      = '0;
    bus.q3      = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
`ifdef COLLECTOR_ACCUM_EN
    bus.clr = 1'b0;
`endif
    reset = 1'b1;
    cycle();
    cycle();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_rd_data", bus.rd_data, '0);
    reset = 1'b0;

    // vld outside COLLECT: error, no write
    bus.vld = 4'b0001;
    bus.q0  = 32'h55;
    cycle();
    bus.vld = '0;
    check("idle_vld_err", bus.err, 1'b1);
    rd_check(0, '0, "idle_vld_mem0");
    pulse_start();
    check("start_clears_err", bus.err, 1'b0);

    feed_skew(1'b0, 1'b0);
    rd_check(6, 32'h102, "addr6");
    read_all();

    // fifth beat on lane 2
    clr_mem();
    pulse_start();
    feed_skew(1'b0, 1'b1);
    check("ovf_err", bus.err, 1'b1);
    rd_check(14, 32'h302, "mem14_kept");

    // start with vld in the middle of a collection
    clr_mem();
    pulse_start();
    bus.vld = 4'b0001; set_q(0, 32'h0);   cycle();
    bus.vld = 4'b0011; set_q(0, 32'h100); set_q(1, 32'h1); cycle();
    bus.start = 1'b1;
    bus.vld   = 4'hF;
    for (int k = 0; k < 4; k++) set_q(k, 32'hBAD0BAD0);
    cycle();
    bus.start = 1'b0;
    bus.vld   = '0;
    check("restart_err", bus.err, 1'b0);
    check("restart_busy", bus.busy, 1'b1);
    feed_skew(1'b0, 1'b0);
    rd_check(5, 32'h101, "restart_addr5");
    read_all();

    // randomized skews and data
    for (int n = 0; n < 4; n++) begin
      clr_mem();
      pulse_start();
      c = 0;
      while (!bus.done && c < 300) begin
        bus.vld = '0;
        for (int k = 0; k < 4; k++) begin
          if (mc[k] < 4 && ($urandom % 2) == 1) bus.vld[k] = 1'b1;
          set_q(k, $urandom);
        end
        bus.rd_en   = ($urandom % 2) == 1;
        bus.rd_addr = 4'($urandom % 16);
        cycle();
        c++;
      end
      bus.vld   = '0;
      bus.rd_en = 1'b0;
      check("rand_done_seen", bus.done, 1'b1);
      read_all();
    end

    // reset after nine writes aborts the collection
    pulse_start();
    bus.vld = 4'hF; for (int k = 0; k < 4; k++) set_q(k, $urandom);
    cycle();
    for (int k = 0; k < 4; k++) set_q(k, $urandom);
    cycle();
    bus.vld = 4'b0001; set_q(0, $urandom);
    cycle();
    bus.vld = '0;
    reset   = 1'b1;
    cycle();
    reset = 1'b0;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_rd_vld", bus.rd_vld, 1'b0);
    cycle();
    cycle();
    check("mid_rst_no_done", bus.done, 1'b0);
    read_all();

`ifdef COLLECTOR_ACCUM_EN
    clr_mem();
    pulse_start();
    feed_skew(1'b1, 1'b0);
    pulse_start();
    feed_skew(1'b1, 1'b0);
    rd_check(0, 32'hFFFFFFFE, "accum_addr0");
    clr_mem();
    read_all();
    rd_check(15, '0, "accum_clr_addr15");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
